// File: rtl/pdp8l_mem_pkg.sv
// Shared types for the PDP-8/L memory cycle sequencer: word width, client
// mode encodings, sequencer states and the modify-stage data path.
package pdp8l_mem_pkg;

  localparam int WORD_W          = 12;
  localparam int TIMEOUT_DEFAULT = 200;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MODE_READ  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_INCR  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_READ,
    ST_MODIFY,
    ST_WRITE,
    ST_DONE,
    ST_DRAIN,
    ST_ERR
  } state_e;

  // Word written back during the restore half of the core cycle.
  function automatic word_t modify_word(input mode_e m, input word_t rbuf, input word_t wdata);
    word_t w;
    case (m)
      MODE_READ:  w = rbuf;
      MODE_WRITE: w = wdata;
      MODE_INCR:  w = rbuf + word_t'(1);
      default:    w = '0;
    endcase
    return w;
  endfunction

  function automatic logic incr_wraps(input mode_e m, input word_t rbuf);
    return (m == MODE_INCR) && (rbuf == '1);
  endfunction

endpackage

// File: rtl/pdp8l_memseq_if.sv
// Client handshake plus memory-controller timing bus of the sequencer.
interface pdp8l_memseq_if;
  import pdp8l_mem_pkg::*;

  logic        req;
  logic [1:0]  mode;
  word_t       addr;
  word_t       wdata;
  logic        busy;
  logic        ack;
  word_t       rdata;
  logic        ovf;
  logic        err;
  logic        memstart;
  logic        select;
  word_t       maddr;
  word_t       mdout;
  logic        memenab;
  logic        strobe;
  logic        cycdone;
  logic        memdone;
  word_t       mdin;

  modport master (
    output req, mode, addr, wdata, memenab, strobe, cycdone, memdone, mdin,
    input  busy, ack, rdata, ovf, err, memstart, select, maddr, mdout
  );

  modport slave (
    input  req, mode, addr, wdata, memenab, strobe, cycdone, memdone, mdin,
    output busy, ack, rdata, ovf, err, memstart, select, maddr, mdout
  );

endinterface

// File: rtl/pdp8l_memseq.sv
// PDP-8/L core memory cycle sequencer: one read-modify-write per client
// request, all timing gated by CSTEP, with a per-cycle watchdog.
//
// state  | meaning
// IDLE   | waiting for req with the controller quiet (memenab=0)
// START  | memstart raised for one CSTEP cycle
// READ   | waiting for strobe to capture sense data
// MODIFY | wbuf formed, waiting for cycdone to begin restore
// WRITE  | mdout driven, waiting for memdone
// DONE   | ack with result
// DRAIN  | waiting for memenab=0 before accepting another request
// ERR    | ack with err=1, result registers untouched
module pdp8l_memseq
  import pdp8l_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          CSTEP,
  pdp8l_memseq_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LIMIT = cnt_t'(TIMEOUT);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   busy_q, busy_d;
  logic   ack_q, ack_d;
  word_t  rdata_q, rdata_d;
  logic   ovf_q, ovf_d;
  logic   err_q, err_d;
  logic   select_q, select_d;
  word_t  maddr_q, maddr_d;
  word_t  mdout_q, mdout_d;
  mode_e  mode_q, mode_d;
  word_t  wdata_q, wdata_d;
  word_t  rbuf_q, rbuf_d;

  cnt_t   cnt_inc;
  logic   timeout_hit;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      select_q <= 1'b0;
      maddr_q  <= '0;
      mdout_q  <= '0;
      mode_q   <= MODE_READ;
      wdata_q  <= '0;
      rbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      select_q <= select_d;
      maddr_q  <= maddr_d;
      mdout_q  <= mdout_d;
      mode_q   <= mode_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    select_d    = select_q;
    maddr_d     = maddr_q;
    mdout_d     = mdout_q;
    mode_d      = mode_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    cnt_inc     = cnt_q + cnt_t'(1);
    timeout_hit = (cnt_inc >= CNT_LIMIT);

    if (CSTEP) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req && !bus.memenab) begin
            mode_d   = mode_e'(bus.mode);
            wdata_d  = bus.wdata;
            maddr_d  = bus.addr;
            select_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = ST_START;
          end
        end
        ST_START: begin
          cnt_d   = cnt_inc;
          state_d = timeout_hit ? ST_ERR : ST_READ;
        end
        ST_READ: begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = ST_ERR;
          end else if (bus.strobe) begin
            rbuf_d  = bus.mdin;
            state_d = ST_MODIFY;
          end else if (bus.cycdone) begin
            // restore began without a strobe: sense data was lost
            state_d = ST_ERR;
          end
        end
        ST_MODIFY: begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = ST_ERR;
          end else if (bus.cycdone) begin
            mdout_d = modify_word(mode_q, rbuf_q, wdata_q);
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          cnt_d = cnt_inc;
          if (bus.memdone) begin
            mdout_d = '0;
            state_d = ST_DONE;
          end else if (timeout_hit) begin
            state_d = ST_ERR;
          end
        end
        ST_DONE: begin
          ack_d   = 1'b1;
          rdata_d = rbuf_q;
          ovf_d   = incr_wraps(mode_q, rbuf_q);
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
        ST_ERR: begin
          ack_d   = 1'b1;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.memenab) begin
            busy_d   = 1'b0;
            select_d = 1'b0;
            maddr_d  = '0;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Release the bank as soon as a failure is decided, not a cycle later.
    if (state_d == ST_ERR && state_q != ST_ERR) begin
      select_d = 1'b0;
      mdout_d  = '0;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
  assign bus.memstart = (state_q == ST_START);
  assign bus.select   = select_q;
  assign bus.maddr    = maddr_q;
  assign bus.mdout    = mdout_q;

endmodule

// File: tb/tb_pdp8l_memseq.sv
// Bench for pdp8l_memseq: table of read-modify-write cycles against a
// scripted controller, plus timeout, CSTEP-throttled back-to-back and reset.
module tb_pdp8l_memseq;
  import pdp8l_mem_pkg::*;

  localparam int TO = 200;

  logic CLOCK, RESET_N, CSTEP;
  pdp8l_memseq_if bus();

  pdp8l_memseq #(.TIMEOUT(TO)) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .CSTEP  (CSTEP),
    .bus    (bus)
  );

  typedef struct {
    mode_e mode;
    word_t addr;
    word_t wdata;
    word_t mdin;
    word_t exp_mdout;
    word_t exp_rdata;
    logic  exp_ovf;
  } vec_t;

  typedef struct {
    word_t rdata;
    logic  ovf;
    logic  err;
  } exp_t;

  vec_t vecs[7];
  vec_t v_extra;
  exp_t sb_q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   memstart_cnt = 0;
  int   ack_cnt = 0;
  int   div = 1;
  int   phase = 0;
  logic ms_prev = 1'b0;
  logic ack_prev = 1'b0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t, bench did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0o expected %0o", name, act, exp);
  endtask

  // Scoreboard side: every ack is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge CLOCK);
      if (bus.memstart === 1'b1 && !ms_prev) memstart_cnt++;
      ms_prev = (bus.memstart === 1'b1);
      if (bus.ack === 1'b1) begin
        ack_cnt++;
        check("ack_single_clock", int'(ack_prev), 0);
        check("ack_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("rdata", int'(bus.rdata), int'(e.rdata));
          check("ovf", int'(bus.ovf), int'(e.ovf));
          check("err", int'(bus.err), int'(e.err));
        end
      end
      ack_prev = (bus.ack === 1'b1);
    end
  end

  // One CLOCK; CSTEP for the coming rising edge is set here.
  task automatic clk1();
    @(negedge CLOCK);
    #1;
    phase = (phase + 1) % div;
    CSTEP = (phase == 0);
  endtask

  // Consume exactly one CSTEP-qualified rising edge.
  task automatic qstep();
    do clk1(); while (CSTEP !== 1'b1);
  endtask

  task automatic run_txn(input vec_t v, input int exp_wait, input bit hold_req, input int drain_hold);
    int ms0, a0, waited;
    ms0 = memstart_cnt;
    a0 = ack_cnt;
    waited = 0;
    bus.req = 1'b1;
    bus.mode = v.mode;
    bus.addr = v.addr;
    bus.wdata = v.wdata;
    sb_q.push_back('{v.exp_rdata, v.exp_ovf, 1'b0});
    do begin qstep(); waited++; end while (bus.memstart !== 1'b1 && waited < 20);
    check("start_wait", waited, exp_wait);
    check("one_memstart", memstart_cnt, ms0 + 1);
    check("select_on", int'(bus.select), 1);
    check("busy_on", int'(bus.busy), 1);
    check("maddr_latched", int'(bus.maddr), int'(v.addr));
    // request fields change while busy; the latched copy must win
    bus.mode = ~v.mode;
    bus.addr = ~v.addr;
    bus.wdata = ~v.wdata;
    bus.memenab = 1'b1;
    qstep();
    check("memstart_one_cstep", int'(bus.memstart), 0);
    bus.strobe = 1'b1;
    bus.mdin = v.mdin;
    qstep();
    bus.strobe = 1'b0;
    bus.mdin = ~v.mdin;
    bus.cycdone = 1'b1;
    qstep();
    bus.cycdone = 1'b0;
    check("mdout_at_write", int'(bus.mdout), int'(v.exp_mdout));
    qstep();
    check("mdout_held", int'(bus.mdout), int'(v.exp_mdout));
    check("maddr_stable", int'(bus.maddr), int'(v.addr));
    bus.memdone = 1'b1;
    qstep();
    bus.memdone = 1'b0;
    check("mdout_cleared", int'(bus.mdout), 0);
    if (drain_hold == 0) bus.memenab = 1'b0;
    qstep();
    check("ack_seen", ack_cnt, a0 + 1);
    if (!hold_req) bus.req = 1'b0;
    for (int i = 0; i < drain_hold; i++) begin
      qstep();
      check("no_overlap", memstart_cnt, ms0 + 1);
      check("busy_in_drain", int'(bus.busy), 1);
    end
    bus.memenab = 1'b0;
    if (!hold_req) begin
      qstep();
      check("busy_off", int'(bus.busy), 0);
      check("select_off", int'(bus.select), 0);
      check("maddr_off", int'(bus.maddr), 0);
    end
  endtask

  initial begin
    int n, a0, ms0;

    vecs[0] = '{MODE_READ,  12'o0123, 12'o0000, 12'o4567, 12'o4567, 12'o4567, 1'b0};
    vecs[1] = '{MODE_WRITE, 12'o0200, 12'o1234, 12'o0777, 12'o1234, 12'o0777, 1'b0};
    vecs[2] = '{MODE_INCR,  12'o0300, 12'o5555, 12'o7777, 12'o0000, 12'o7777, 1'b1};
    vecs[3] = '{MODE_CLEAR, 12'o7777, 12'o1111, 12'o5252, 12'o0000, 12'o5252, 1'b0};
    vecs[4] = '{MODE_INCR,  12'o0301, 12'o0000, 12'o0005, 12'o0006, 12'o0005, 1'b0};
    vecs[5] = '{MODE_WRITE, 12'o4000, 12'o7777, 12'o0000, 12'o7777, 12'o0000, 1'b0};
    vecs[6] = '{MODE_INCR,  12'o1234, 12'o0000, 12'o3777, 12'o4000, 12'o3777, 1'b0};

    RESET_N = 1'b0;
    CSTEP = 1'b1;
    bus.req = 1'b0;
    bus.mode = 2'b00;
    bus.addr = '0;
    bus.wdata = '0;
    bus.memenab = 1'b0;
    bus.strobe = 1'b0;
    bus.cycdone = 1'b0;
    bus.memdone = 1'b0;
    bus.mdin = '0;
    repeat (2) @(negedge CLOCK);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_ack", int'(bus.ack), 0);
    check("reset_memstart", int'(bus.memstart), 0);
    check("reset_select", int'(bus.select), 0);
    check("reset_maddr", int'(bus.maddr), 0);
    check("reset_mdout", int'(bus.mdout), 0);
    check("reset_rdata", int'(bus.rdata), 0);
    RESET_N = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], 1, 1'b0, 0);

    // Controller never returns memdone: ERR decided on the TO-th CSTEP cycle
    // counted from START, ack follows on the next one.
    a0 = ack_cnt;
    bus.req = 1'b1;
    bus.mode = MODE_READ;
    bus.addr = 12'o0456;
    sb_q.push_back('{vecs[6].exp_rdata, 1'b0, 1'b1});
    qstep();
    check("to_memstart", int'(bus.memstart), 1);
    bus.memenab = 1'b1;
    n = 0;
    qstep(); n++;
    bus.strobe = 1'b1;
    bus.mdin = 12'o1111;
    qstep(); n++;
    bus.strobe = 1'b0;
    bus.cycdone = 1'b1;
    qstep(); n++;
    bus.cycdone = 1'b0;
    while (ack_cnt == a0 && n < TO + 20) begin
      qstep(); n++;
      if (n == TO - 1) check("to_select_before", int'(bus.select), 1);
      if (n == TO) begin
        check("to_select_dropped", int'(bus.select), 0);
        check("to_mdout_dropped", int'(bus.mdout), 0);
        check("to_busy_held", int'(bus.busy), 1);
      end
    end
    check("to_ack_cycle", n, TO + 1);
    bus.req = 1'b0;
    bus.memenab = 1'b0;
    qstep();
    check("to_busy_off", int'(bus.busy), 0);

    v_extra = '{MODE_READ, 12'o0456, 12'o0000, 12'o2345, 12'o2345, 12'o2345, 1'b0};
    run_txn(v_extra, 1, 1'b0, 0);

    // CSTEP one clock in four, req held across back-to-back cycles.
    div = 4;
    phase = 0;
    v_extra = '{MODE_WRITE, 12'o0010, 12'o6543, 12'o0101, 12'o6543, 12'o0101, 1'b0};
    run_txn(v_extra, 1, 1'b1, 3);
    v_extra = '{MODE_INCR, 12'o0011, 12'o0000, 12'o7777, 12'o0000, 12'o7777, 1'b1};
    run_txn(v_extra, 2, 1'b0, 0);
    div = 1;
    phase = 0;

    // Reset in the middle of READ: no ack, restart waits for memenab=0.
    a0 = ack_cnt;
    ms0 = memstart_cnt;
    bus.req = 1'b1;
    bus.mode = MODE_READ;
    bus.addr = 12'o0345;
    qstep();
    check("rst_memstart", int'(bus.memstart), 1);
    bus.memenab = 1'b1;
    qstep();
    check("rst_busy_before", int'(bus.busy), 1);
    RESET_N = 1'b0;
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_memstart_low", int'(bus.memstart), 0);
    check("rst_select", int'(bus.select), 0);
    check("rst_maddr", int'(bus.maddr), 0);
    check("rst_mdout", int'(bus.mdout), 0);
    @(negedge CLOCK);
    #1;
    RESET_N = 1'b1;
    CSTEP = 1'b1;
    repeat (3) qstep();
    check("rst_wait_memenab", memstart_cnt, ms0 + 1);
    check("rst_idle_busy", int'(bus.busy), 0);
    check("rst_no_ack", ack_cnt, a0);
    bus.memenab = 1'b0;
    v_extra = '{MODE_READ, 12'o0700, 12'o0000, 12'o7070, 12'o7070, 12'o7070, 1'b0};
    run_txn(v_extra, 1, 1'b0, 0);

    repeat (3) clk1();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
